// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor: WIDTH bits split into STAGES ripple
// chunks, one chunk per clock, with valid/ready handshaking and a global stall.
module pipelined_add_sub #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);
  localparam int CHUNK = WIDTH / STAGES;

  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Stage k keeps the not-yet-added upper operand bits (B already inverted for
  // subtraction) plus the completed lower result bits; widths shrink/grow per stage.
  for (genvar k = 0; k < STAGES - 1; k++) begin : stg
    localparam int DONE = (k + 1) * CHUNK;
    localparam int REM  = WIDTH - DONE;

    logic             valid_q;
    logic             carry_q;
    logic [REM-1:0]   aRem_q;
    logic [REM-1:0]   bRem_q;
    logic [DONE-1:0]  sum_q;
    logic [REM-1:0]   aRem_d;
    logic [REM-1:0]   bRem_d;
    logic [DONE-1:0]  sum_d;
    logic [CHUNK-1:0] opA;
    logic [CHUNK-1:0] opB;
    logic             cin;
    logic             vin;
    logic [CHUNK:0]   chunkSum;

    if (k == 0) begin : gFirst
      assign opA    = a[CHUNK-1:0];
      assign opB    = b[CHUNK-1:0] ^ {CHUNK{sub}};
      assign cin    = sub;
      assign vin    = in_valid;
      assign aRem_d = a[WIDTH-1:CHUNK];
      assign bRem_d = b[WIDTH-1:CHUNK] ^ {REM{sub}};
      assign sum_d  = chunkSum[CHUNK-1:0];
    end else begin : gNext
      assign opA    = stg[k-1].aRem_q[CHUNK-1:0];
      assign opB    = stg[k-1].bRem_q[CHUNK-1:0];
      assign cin    = stg[k-1].carry_q;
      assign vin    = stg[k-1].valid_q;
      assign aRem_d = stg[k-1].aRem_q[REM+CHUNK-1:CHUNK];
      assign bRem_d = stg[k-1].bRem_q[REM+CHUNK-1:CHUNK];
      assign sum_d  = {chunkSum[CHUNK-1:0], stg[k-1].sum_q};
    end

    assign chunkSum = {1'b0, opA} + {1'b0, opB} + {{CHUNK{1'b0}}, cin};

    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        aRem_q  <= '0;
        bRem_q  <= '0;
        sum_q   <= '0;
      end else if (!stall) begin
        valid_q <= vin;
        if (vin) begin
          carry_q <= chunkSum[CHUNK];
          aRem_q  <= aRem_d;
          bRem_q  <= bRem_d;
          sum_q   <= sum_d;
        end
      end
    end
  end

  logic [CHUNK-1:0] lastA;
  logic [CHUNK-1:0] lastB;
  logic             lastCin;
  logic             lastValid;
  logic [CHUNK:0]   lastSum;
  logic [WIDTH-1:0] result_d;
  logic             msbCarry_d;

  if (STAGES == 1) begin : gSingle
    assign lastA     = a;
    assign lastB     = b ^ {WIDTH{sub}};
    assign lastCin   = sub;
    assign lastValid = in_valid;
    assign result_d  = lastSum[CHUNK-1:0];
  end else begin : gMulti
    assign lastA     = stg[STAGES-2].aRem_q;
    assign lastB     = stg[STAGES-2].bRem_q;
    assign lastCin   = stg[STAGES-2].carry_q;
    assign lastValid = stg[STAGES-2].valid_q;
    assign result_d  = {lastSum[CHUNK-1:0], stg[STAGES-2].sum_q};
  end

  assign lastSum    = {1'b0, lastA} + {1'b0, lastB} + {{CHUNK{1'b0}}, lastCin};
  assign msbCarry_d = lastA[CHUNK-1] ^ lastB[CHUNK-1] ^ lastSum[CHUNK-1];

  logic             outValid_q;
  logic [WIDTH-1:0] result_q;
  logic             carryOut_q;
  logic             msbCarry_q;
  logic             zero_q;

  // Data registers only load on real beats, so they stay zero after reset until one arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      outValid_q <= 1'b0;
      result_q   <= '0;
      carryOut_q <= 1'b0;
      msbCarry_q <= 1'b0;
      zero_q     <= 1'b0;
    end else if (!stall) begin
      outValid_q <= lastValid;
      if (lastValid) begin
        result_q   <= result_d;
        carryOut_q <= lastSum[CHUNK];
        msbCarry_q <= msbCarry_d;
        zero_q     <= (result_d == '0);
      end
    end
  end

  assign out_valid = outValid_q;
  assign result    = result_q;
  assign carry     = carryOut_q;
  assign overflow  = msbCarry_q ^ carryOut_q;
  assign zero      = zero_q;
  assign negative  = result_q[WIDTH-1];
endmodule
